// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame controller.
// Optional feature macro: UART_FRAME_CRC_EN (adds the CRC state and CRC-8 check).
package uart_frame_pkg;

    // Frame parser states; ST_CRC exists only when the CRC check is built in.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
`ifdef UART_FRAME_CRC_EN
        ST_CRC     = 3'd3,
`endif
        ST_DONE    = 3'd4
    } state_t;

    // err_code encodings reported with frame_done
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CRC     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    // CRC-8: polynomial x^8+x^2+x+1, zero init, MSB first
    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

    // Default frame start marker
    localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;

endpackage

// File: rtl/uart_frame_ctrl_crc8_byte.sv
// Combinational CRC-8 update over one byte (MSB first).
// Only instantiated when UART_FRAME_CRC_EN is defined.
module crc8_byte
    import uart_frame_pkg::*;
(
    input  logic [7:0] crc_in,
    input  logic [7:0] data_byte,
    output logic [7:0] crc_out
);

    logic [7:0] c;

    // Fold the byte into the CRC, then run eight shift/XOR steps.
    always_comb begin
        c = crc_in ^ data_byte;
        for (int i = 0; i < 8; i++) begin
            if (c[7]) begin
                c = {c[6:0], 1'b0} ^ CRC8_POLY;
            end else begin
                c = {c[6:0], 1'b0};
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/uart_frame_ctrl.sv
// UART frame controller: parses HDR, LEN, payload[, CRC] frames from a byte
// strobe, forwards payload bytes one cycle later, and reports frame status.
// Optional feature macro: UART_FRAME_CRC_EN (CRC-8 over LEN and payload).
//
// Handshake: data_en is a one-cycle strobe with data_in valid in the same
// cycle; there is no backpressure, so every strobe is consumed (or ignored in
// DONE). pay_valid is likewise a one-cycle strobe with no ready; frame_done is
// a one-cycle pulse with frame_ok/err_code valid only while it is high.
module uart_frame_ctrl
    import uart_frame_pkg::*;
#(
    parameter int         MAX_LEN     = 16,
    parameter int         TIMEOUT_CYC = 52080,
    parameter logic [7:0] HDR_BYTE    = HDR_BYTE_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       data_en,
    input  logic [7:0] data_in,
    output logic       pay_valid,
    output logic [7:0] pay_data,
    output logic       pay_last,
    output logic       frame_done,
    output logic       frame_ok,
    output logic [1:0] err_code,
    output logic       busy
);

    localparam int         TMO_W     = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t           state_q, state_d;
    logic [1:0]       err_q, err_d;
    logic [7:0]       len_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;

    // A strobe arriving on the terminal count wins over the timeout.
    assign tmo_hit = (tmo_cnt == TMO_LAST) && !data_en;

`ifdef UART_FRAME_CRC_EN
    logic [7:0] crc_q;
    logic [7:0] crc_next;

    crc8_byte u_crc8 (
        .crc_in    (crc_q),
        .data_byte (data_in),
        .crc_out   (crc_next)
    );

    // Running CRC: restart in IDLE, accumulate LEN and payload bytes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= CRC8_INIT;
        end else if (state_q == ST_IDLE) begin
            crc_q <= CRC8_INIT;
        end else if (data_en && (state_q == ST_LEN || state_q == ST_PAYLOAD)) begin
            crc_q <= crc_next;
        end
    end
`endif

    // State and latched error code register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: advance on data_en, except DONE and timeout exits.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (data_en && data_in == HDR_BYTE) begin
                    state_d = ST_LEN;
                    err_d   = ERR_NONE;
                end
            end
            ST_LEN: begin
                if (data_en) begin
                    if (data_in == 8'd0 || data_in > MAX_LEN_B) begin
                        state_d = ST_DONE;
                        err_d   = ERR_LEN;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end else if (tmo_hit) begin
                    state_d = ST_DONE;
                    err_d   = ERR_TIMEOUT;
                end
            end
            ST_PAYLOAD: begin
                if (data_en) begin
                    if (len_cnt == 8'd1) begin
`ifdef UART_FRAME_CRC_EN
                        state_d = ST_CRC;
`else
                        state_d = ST_DONE;
`endif
                    end
                end else if (tmo_hit) begin
                    state_d = ST_DONE;
                    err_d   = ERR_TIMEOUT;
                end
            end
`ifdef UART_FRAME_CRC_EN
            ST_CRC: begin
                if (data_en) begin
                    state_d = ST_DONE;
                    err_d   = (data_in != crc_q) ? ERR_CRC : ERR_NONE;
                end else if (tmo_hit) begin
                    state_d = ST_DONE;
                    err_d   = ERR_TIMEOUT;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Length down-counter and registered payload forwarding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_cnt   <= 8'd0;
            pay_valid <= 1'b0;
            pay_data  <= 8'd0;
            pay_last  <= 1'b0;
        end else begin
            pay_valid <= 1'b0;
            pay_last  <= 1'b0;
            if (data_en && state_q == ST_LEN && data_in != 8'd0 && data_in <= MAX_LEN_B) begin
                len_cnt <= data_in;
            end else if (data_en && state_q == ST_PAYLOAD) begin
                len_cnt   <= len_cnt - 8'd1;
                pay_valid <= 1'b1;
                pay_data  <= data_in;
                pay_last  <= (len_cnt == 8'd1);
            end
        end
    end

    // Inter-byte idle counter: clears on a strobe or in IDLE, saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (data_en || state_q == ST_IDLE) begin
            tmo_cnt <= '0;
        end else if (tmo_cnt != TMO_LAST) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Status outputs decoded from the state and latched error.
    always_comb begin
        frame_done = (state_q == ST_DONE);
        frame_ok   = (state_q == ST_DONE) && (err_q == ERR_NONE);
        err_code   = (state_q == ST_DONE) ? err_q : ERR_NONE;
        busy       = (state_q != ST_IDLE);
    end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Directed bench for uart_frame_ctrl with payload/status scoreboards.
// Adapts to UART_FRAME_CRC_EN (sends the CRC byte only when it is defined).
module tb_uart_frame_ctrl;

    localparam int TMO  = 40;
    localparam int MAXL = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       data_en = 1'b0;
    logic [7:0] data_in = 8'd0;
    logic       pay_valid, pay_last, frame_done, frame_ok, busy;
    logic [7:0] pay_data;
    logic [1:0] err_code;

    int n_cmp = 0;
    int n_err = 0;

    logic [8:0] exp_pay[$];   // {last, data}
    logic [2:0] exp_done[$];  // {ok, err_code}
    logic [7:0] pay_buf[256];

    uart_frame_ctrl #(.MAX_LEN(MAXL), .TIMEOUT_CYC(TMO), .HDR_BYTE(8'hA5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_en    (data_en),
        .data_in    (data_in),
        .pay_valid  (pay_valid),
        .pay_data   (pay_data),
        .pay_last   (pay_last),
        .frame_done (frame_done),
        .frame_ok   (frame_ok),
        .err_code   (err_code),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bit-serial reference CRC-8 (poly 0x07, MSB first).
    function automatic logic [7:0] crc8_model(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        logic       fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[7] ^ d[i];
            r  = {r[6:0], 1'b0};
            if (fb) r = r ^ 8'h07;
        end
        return r;
    endfunction

    // Scoreboard: pop expected entries as the DUT produces them.
    always @(negedge clk) begin
        if (rst_n) begin
            if (pay_valid) begin
                chk("pay_expected", 32'(exp_pay.size() > 0), 32'd1);
                if (exp_pay.size() > 0) chk("pay", 32'({pay_last, pay_data}), 32'(exp_pay.pop_front()));
            end
            if (frame_done) begin
                chk("done_expected", 32'(exp_done.size() > 0), 32'd1);
                if (exp_done.size() > 0) chk("done_status", 32'({frame_ok, err_code}), 32'(exp_done.pop_front()));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        data_en = 1'b1;
        data_in = b;
        @(posedge clk); #1;
        data_en = 1'b0;
    endtask

    task automatic send_frame(input int len, input bit corrupt);
        logic [7:0] crc;
        crc = crc8_model(8'h00, 8'(len));
`ifdef UART_FRAME_CRC_EN
        exp_done.push_back(corrupt ? {1'b0, 2'd2} : {1'b1, 2'd0});
`else
        exp_done.push_back({1'b1, 2'd0});
`endif
        send_byte(8'hA5);
        send_byte(8'(len));
        for (int i = 0; i < len; i++) begin
            crc = crc8_model(crc, pay_buf[i]);
            exp_pay.push_back({(i == len - 1), pay_buf[i]});
            send_byte(pay_buf[i]);
        end
`ifdef UART_FRAME_CRC_EN
        send_byte(corrupt ? (crc ^ 8'h01) : crc);
`endif
        @(negedge clk);
        chk("done_timing", 32'(frame_done), 32'd1);
    endtask

    task automatic send_len_err(input logic [7:0] len);
        exp_done.push_back({1'b0, 2'd1});
        send_byte(8'hA5);
        send_byte(len);
        @(negedge clk);
        chk("len_done_timing", 32'(frame_done), 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int         idx;
        logic [7:0] crc;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_pay_valid", 32'(pay_valid), 32'd0);
        chk("rst_pay_data", 32'(pay_data), 32'd0);
        chk("rst_pay_last", 32'(pay_last), 32'd0);
        chk("rst_status", 32'({frame_done, frame_ok, err_code}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Good two-byte frame
        pay_buf[0] = 8'h11; pay_buf[1] = 8'h22;
        send_frame(2, 1'b0);

        // Same frame with a corrupted CRC byte
        send_frame(2, 1'b1);

        // Length errors: zero and MAX_LEN+1
        send_len_err(8'h00);
        send_len_err(8'h11);

        // Leading garbage ignored, header value accepted as payload
        send_byte(8'h00);
        send_byte(8'hFF);
        @(negedge clk);
        chk("garbage_idle", 32'(busy), 32'd0);
        pay_buf[0] = 8'hA5;
        send_frame(1, 1'b0);

        // Maximum length frame with random payload
        for (int i = 0; i < MAXL; i++) pay_buf[i] = 8'($urandom_range(0, 255));
        send_frame(MAXL, 1'b0);

        // Timeout after one payload byte
        exp_pay.push_back({1'b0, 8'hAA});
        exp_done.push_back({1'b0, 2'd3});
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'hAA);
        idx = -1;
        for (int k = 0; k < TMO + 10; k++) begin
            @(negedge clk);
            if (frame_done) begin
                idx = k;
                break;
            end
        end
        chk("tmo_latency", 32'(idx), 32'(TMO));
        @(negedge clk);
        chk("tmo_busy", 32'(busy), 32'd0);

        // Strobe landing on the timeout terminal count keeps the frame alive
        pay_buf[0] = 8'h5A; pay_buf[1] = 8'h6B; pay_buf[2] = 8'h7C;
        exp_done.push_back({1'b1, 2'd0});
        send_byte(8'hA5);
        send_byte(8'h03);
        crc = crc8_model(8'h00, 8'h03);
        repeat (TMO - 2) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            crc = crc8_model(crc, pay_buf[i]);
            exp_pay.push_back({(i == 2), pay_buf[i]});
            send_byte(pay_buf[i]);
        end
`ifdef UART_FRAME_CRC_EN
        send_byte(crc);
`endif
        @(negedge clk);
        chk("race_done_timing", 32'(frame_done), 32'd1);

        // Reset in the middle of a frame: no frame_done, then a good frame
        exp_pay.push_back({1'b0, 8'h11});
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h11);
        @(negedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_outs", 32'({pay_valid, frame_done, busy}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        pay_buf[0] = 8'h33; pay_buf[1] = 8'h44;
        send_frame(2, 1'b0);

        repeat (5) @(negedge clk);
        chk("pay_q_empty", 32'(exp_pay.size()), 32'd0);
        chk("done_q_empty", 32'(exp_done.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
